// File: rtl/sipo_framer.sv
`default_nettype none
// ============================================================================
// Module   : sipo_framer
// Brief    : Serial-in/parallel-out framer with a fill buffer and output register.
// Revision : 1.0 - initial release
// ============================================================================
module sipo_framer #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  parameter int ORDER  = 0,
  parameter int CW     = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [DATA_W-1:0]       s_data,
  input  logic                    s_last,
  output logic                    p_valid,
  input  logic                    p_ready,
  output logic [DEPTH*DATA_W-1:0] p_data,
  output logic [CW-1:0]           p_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [0:0] ST_FILL = 1'b0;
  localparam logic [0:0] ST_PEND = 1'b1;

  logic [0:0]              r_state;
  logic [0:0]              w_state_nxt;
  logic [DATA_W-1:0]       r_buf [DEPTH];
  logic [CW-1:0]           r_fill;
  logic [CW-1:0]           r_pend_cnt;
  logic                    w_pend;
  logic                    w_in_acc;
  logic                    w_out_acc;
  logic                    w_slot_free;
  logic                    w_complete;
  logic                    w_load;
  logic [CW-1:0]           w_src_cnt;
  logic [DATA_W-1:0]       w_words [DEPTH];
  logic [DEPTH*DATA_W-1:0] w_frame;

  assign w_in_acc    = s_valid & s_ready;
  assign w_out_acc   = p_valid & p_ready;
  assign w_slot_free = ~p_valid | p_ready;
  assign w_complete  = w_in_acc & (s_last | (r_fill == CW'(DEPTH - 1)));
  assign w_load      = (w_complete & w_slot_free) | (w_pend & w_out_acc);
  assign w_src_cnt   = w_pend ? r_pend_cnt : (r_fill + CW'(1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_FILL;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_FILL: if (w_complete && !w_slot_free) w_state_nxt = ST_PEND;
      ST_PEND: if (w_out_acc)                  w_state_nxt = ST_FILL;
      default: w_state_nxt = ST_FILL;
    endcase
  end

  // Output decode
  always_comb begin
    s_ready = (r_state == ST_FILL);
    w_pend  = (r_state == ST_PEND);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fill     <= '0;
      r_pend_cnt <= '0;
    end else begin
      if (w_complete)    r_fill <= '0;
      else if (w_in_acc) r_fill <= r_fill + CW'(1);
      if (w_complete && !w_slot_free) r_pend_cnt <= r_fill + CW'(1);
    end
  end

  // Every accepted word is stored, so a frame held back as pending is complete in r_buf.
  always_ff @(posedge clk) begin
    if (w_in_acc) r_buf[r_fill[AW-1:0]] <= s_data;
  end

  // Word view: while filling, the incoming word stands in at the fill position.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_words[i] = r_buf[i];
      if (!w_pend && (i == int'(r_fill))) w_words[i] = s_data;
    end
  end

  always_comb begin
    w_frame = '0;
    for (int j = 0; j < DEPTH; j++) begin
      if (j < int'(w_src_cnt)) begin
        if (ORDER != 0) w_frame[j*DATA_W +: DATA_W] = w_words[AW'(j)];
        else            w_frame[j*DATA_W +: DATA_W] = w_words[AW'(int'(w_src_cnt) - 1 - j)];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_valid <= 1'b0;
      p_data  <= '0;
      p_count <= '0;
    end else begin
      if (w_load) begin
        p_valid <= 1'b1;
        p_data  <= w_frame;
        p_count <= w_src_cnt;
      end else if (w_out_acc) begin
        p_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sipo_framer.sv
`default_nettype none
// ============================================================================
// Module   : tb_sipo_framer
// Brief    : Scoreboard bench for sipo_framer, DEPTH=4 in both slice orders.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sipo_framer;

  localparam int DW = 32;
  localparam int DP = 4;
  localparam int CWL = $clog2(DP + 1);
  localparam int FW = DP * DW;

  typedef struct {
    logic [FW-1:0] f0;
    logic [FW-1:0] f1;
    int            cnt;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            s_valid = 1'b0;
  logic [DW-1:0]   s_data = '0;
  logic            s_last = 1'b0;
  logic            p_ready = 1'b0;
  logic            s_ready0, s_ready1, p_valid0, p_valid1;
  logic [FW-1:0]   p_data0, p_data1;
  logic [CWL-1:0]  p_count0, p_count1;

  int total = 0;
  int bad = 0;

  exp_t          sb[$];
  logic [DW-1:0] m_w [DP];
  int            m_n = 0;
  logic          m_pv = 1'b0;
  logic          m_pend = 1'b0;

  always #5 clk = ~clk;

  sipo_framer #(.DATA_W(DW), .DEPTH(DP), .ORDER(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready0),
    .s_data(s_data), .s_last(s_last), .p_valid(p_valid0), .p_ready(p_ready),
    .p_data(p_data0), .p_count(p_count0));

  sipo_framer #(.DATA_W(DW), .DEPTH(DP), .ORDER(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready1),
    .s_data(s_data), .s_last(s_last), .p_valid(p_valid1), .p_ready(p_ready),
    .p_data(p_data1), .p_count(p_count1));

  task automatic check(input string tag, input logic [FW-1:0] got, input logic [FW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [FW-1:0] build(input int ord);
    logic [FW-1:0] f;
    f = '0;
    for (int j = 0; j < m_n; j++)
      f[j*DW +: DW] = (ord != 0) ? m_w[j] : m_w[m_n - 1 - j];
    return f;
  endfunction

  task automatic check_status();
    check("s_ready0", FW'(s_ready0), FW'(!m_pend));
    check("s_ready1", FW'(s_ready1), FW'(!m_pend));
    check("p_valid0", FW'(p_valid0), FW'(m_pv));
    check("p_valid1", FW'(p_valid1), FW'(m_pv));
    if (m_pv) begin
      if (sb.size() == 0) begin
        check("sb_empty", FW'(1), FW'(0));
      end else begin
        check("p_data0", p_data0, sb[0].f0);
        check("p_data1", p_data1, sb[0].f1);
        check("p_count0", FW'(p_count0), FW'(sb[0].cnt));
        check("p_count1", FW'(p_count1), FW'(sb[0].cnt));
      end
    end
  endtask

  // One clock: compare outputs, drive the inputs, advance the reference model.
  task automatic cycle(input logic v, input logic [DW-1:0] d, input logic l, input logic pr);
    logic oacc, iacc, pv0, npv;
    exp_t e;
    @(negedge clk);
    check_status();
    s_valid = v; s_data = d; s_last = l; p_ready = pr;
    pv0  = m_pv;
    oacc = pv0 & pr;
    iacc = v & !m_pend;
    npv  = pv0 & !oacc;
    if (oacc && sb.size() > 0) void'(sb.pop_front());
    if (m_pend && oacc) begin
      m_pend = 1'b0;
      npv = 1'b1;
    end
    if (iacc) begin
      m_w[m_n] = d;
      m_n++;
      if (l || m_n == DP) begin
        e.f0 = build(0);
        e.f1 = build(1);
        e.cnt = m_n;
        sb.push_back(e);
        if (!pv0 || pr) npv = 1'b1;
        else m_pend = 1'b1;
        m_n = 0;
      end
    end
    m_pv = npv;
  endtask

  task automatic do_reset();
    @(negedge clk);
    check_status();
    s_valid = 1'b0; s_last = 1'b0; p_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_p_valid0", FW'(p_valid0), FW'(0));
    check("rst_p_valid1", FW'(p_valid1), FW'(0));
    check("rst_s_ready0", FW'(s_ready0), FW'(1));
    check("rst_s_ready1", FW'(s_ready1), FW'(1));
    check("rst_p_count0", FW'(p_count0), FW'(0));
    check("rst_p_data0", p_data0, '0);
    check("rst_p_data1", p_data1, '0);
    sb.delete();
    m_n = 0; m_pv = 1'b0; m_pend = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    #23 rst_n = 1'b1;

    // Reset values observed before any stimulus
    cycle(0, 0, 0, 0);

    // Full frame, no s_last
    cycle(1, 32'h11, 0, 1);
    cycle(1, 32'h22, 0, 1);
    cycle(1, 32'h33, 0, 1);
    cycle(1, 32'h44, 0, 1);
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 1);

    // Partial frame ended by s_last
    cycle(1, 32'hA, 0, 1);
    cycle(1, 32'hB, 0, 1);
    cycle(1, 32'hC, 1, 1);
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 1);

    // Back-pressure: second frame goes pending, extra word refused
    for (int i = 0; i < 8; i++) cycle(1, DW'(32'h100 + i), 0, 0);
    cycle(1, 32'h999, 0, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 0);

    // Full-rate streaming
    for (int i = 0; i < 40; i++) cycle(1, DW'(i + 1), 0, 1);
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 1);

    // Single-word frame
    cycle(1, 32'h5, 1, 1);
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 1);

    // Reset mid-frame
    cycle(1, 32'h71, 0, 1);
    cycle(1, 32'h72, 0, 1);
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1, DW'(32'h81 + i), 0, 1);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 1);

    // Reset while a frame is held and another pending
    for (int i = 0; i < 8; i++) cycle(1, DW'(32'h200 + i), 0, 0);
    cycle(0, 0, 0, 0);
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1, DW'(32'h301 + i), 0, 1);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 1);

    if (sb.size() != 0) check("sb_leftover", FW'(sb.size()), FW'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sipo_framer.md
Name: sipo_framer

Overview:
- Parametrised serial-in/parallel-out framer with valid/ready handshakes on both sides.
- Collects DEPTH words, or fewer if ended by s_last, into one parallel frame and holds it until the consumer accepts it.
- Has a fill buffer plus an output register, so input streams without bubbles while the PE array consumes frames.
- Selectable slice ordering; zero-padding of partial frames.

Parameters:
- DATA_W, 32, width of one serial word (two packed DATA_WIDTH=16 operands).
- DEPTH, 8, words per full frame; legal range 2..64.
- ORDER, 0, p_data slice ordering: 0 = newest word in slice 0, 1 = first-received word in slice 0.
- CW, $clog2(DEPTH+1), width of p_count (derived; do not override).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- s_valid  in  1  serial word valid
- s_ready  out  1  framer can accept a word
- s_data  in  DATA_W  serial word
- s_last  in  1  qualifies s_data as final word of a frame; ends a partial frame
- p_valid  out  1  parallel frame valid
- p_ready  in  1  consumer accepts frame
- p_data  out  DEPTH*DATA_W  frame; slice j = p_data[(j+1)*DATA_W-1 : j*DATA_W]
- p_count  out  CW  number of valid words in frame, range 1..DEPTH

Behaviour:
- Reset (async assert, sync-released deassert): p_valid=0, p_data=0, p_count=0, fill count=0, pending=0, s_ready=1. Any partial or held frame is discarded.
- Handshakes:
  - Input accept = s_valid & s_ready.
  - Output accept = p_valid & p_ready.
  - s_data and s_last are ignored when s_valid=0.
- Fill buffer stores words 0..n-1 of the current frame and has a fill counter 0..DEPTH-1.
- A frame completes on the accept of word DEPTH-1, or on the accept of any word with s_last=1. n = words in the frame, including that word.
- On the completing edge with output slot free (p_valid=0 or p_ready=1):
  - p_data and p_count load the frame, including the incoming word.
  - p_valid=1 from the next cycle.
  - Fill counter clears.
  - Latency: last word accepted at edge t → p_valid high after edge t. No extra cycle.
- On the completing edge with slot busy (p_valid=1, p_ready=0):
  - Frame is held in the fill buffer; pending=1.
  - s_ready=0 while pending=1.
  - On the edge where the output is accepted, the pending frame moves into p_data; pending clears; s_ready returns to 1 the next cycle.
- s_ready = !pending. It is registered-state based, with no combinational path from s_valid. The p_ready→s_ready path is not combinational either.
- Output accept with no new frame: p_valid→0. p_data and p_count hold their last values (don't-care).
- p_data and p_count are stable while p_valid=1 and p_ready=0.
- Ordering for frame words w0..w(n-1):
  - ORDER=0: slice j = w(n-1-j) for j<n.
  - ORDER=1: slice j = wj for j<n.
  - Slices j>=n are always 0.
- Full-rate streaming with p_ready=1 held: one word accepted every cycle, no bubbles; a frame emitted every DEPTH cycles.
- A single-word frame (s_last on first word) is legal: p_count=1.
- Simultaneous output accept and frame completion on the same edge: new frame loads and p_valid stays 1 (back-to-back).
- Pending never overlaps a partially filled buffer. While pending=1, no input is accepted.
- Reset asserted mid-frame or mid-hold: immediate clear per reset values. The first frame after reset starts at word 0.

Test Plan:
- DEPTH=4, ORDER=0, p_ready=1, stream 0x11,0x22,0x33,0x44 with no s_last → one cycle after the 4th accept: p_valid=1, p_count=4, slices 0..3 = 0x44,0x33,0x22,0x11.
- ORDER=1, words 0xA,0xB then 0xC with s_last=1 → p_count=3; slices = 0xA,0xB,0xC,0; s_ready stays 1 throughout.
- p_ready=0; feed 8 words (two frames) → first frame held stable; after the 8th accept, s_ready=0. Raise p_ready for 1 cycle → second frame appears next cycle with p_valid=1 and s_ready=1. No word is lost or duplicated.
- Continuous s_valid=1 and p_ready=1 for 40 cycles with an incrementing counter → 10 frames, p_valid pulses every 4 cycles, s_ready never drops, slices match the counter.
- Single word 0x5 with s_last=1 → p_count=1, slice 0 = 0x5, all other slices 0, for both ORDER values.
- Assert rst_n=0 after 2 words of a frame and also during a held frame → p_valid=0 and s_ready=1 immediately. Next 4 words form a clean frame with p_count=4.
